// File: rtl/pdm_capture_ctrl_if.sv
// pdm_capture_ctrl_if
//   Valid/ready word stream from the capture controller's output FIFO to
//   the downstream audio storage/playback logic.
//   valid : head word present
//   ready : consumer accepts head when valid & ready
//   data  : head word
//   last  : head is the final word of a count-terminated session
interface pdm_capture_ctrl_if #(
    parameter int WORD_W = 16
) ();
    logic              valid;
    logic              ready;
    logic [WORD_W-1:0] data;
    logic              last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/pdm_capture_ctrl.sv
// pdm_capture_ctrl
//   Sequences the PDM microphone deserializer for one capture session:
//   start/stop, warm-up word discard, channel select, and a small
//   first-word-fall-through FIFO feeding a valid/ready output stream.
// Ports
//   clock, reset_n   : rising-edge clock, synchronous active-low reset
//   start, stop      : session control pulses
//   num_words        : words to capture (0 = until stop), latched on start
//   channel_sel      : mic channel, latched on start
//   des_enable_o     : deserializer enable (registered)
//   des_irsel_o      : latched channel select (registered)
//   des_done_i/des_data_i : finished word strobe and word
//   m                : output stream (master modport)
//   busy_o, capture_done_o, overflow_o, drop_cnt_o : session status
module pdm_capture_ctrl #(
    parameter int WORD_W       = 16,
    parameter int FIFO_DEPTH   = 8,
    parameter int WARMUP_WORDS = 4,
    parameter int CNT_W        = 20
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   stop,
    input  logic [CNT_W-1:0]       num_words,
    input  logic                   channel_sel,
    output logic                   des_enable_o,
    output logic                   des_irsel_o,
    input  logic                   des_done_i,
    input  logic [WORD_W-1:0]      des_data_i,
    pdm_capture_ctrl_if.master     m,
    output logic                   busy_o,
    output logic                   capture_done_o,
    output logic                   overflow_o,
    output logic [7:0]             drop_cnt_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]   DEPTH_L  = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] WARMUP_L = CNT_W'(WARMUP_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WARMUP  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_FLUSH   = 2'd3
    } state_t;

    state_t            state_r, next_state_s;
    logic [CNT_W-1:0]  num_words_r, warm_cnt_r, cap_cnt_r;
    logic [CNT_W-1:0]  warm_inc_s, cap_inc_s;
    logic              des_enable_r, irsel_r, busy_r, capture_done_r, overflow_r;
    logic [7:0]        drop_cnt_r;
    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
    logic [PTR_W:0]    count_r;
    logic [WORD_W-1:0] mem_data_r [FIFO_DEPTH];
    logic              mem_last_r [FIFO_DEPTH];
    logic              push_s, pop_s, drop_s, final_s;

    assign warm_inc_s = warm_cnt_r + CNT_W'(1);
    assign cap_inc_s  = cap_cnt_r + CNT_W'(1);

    // Next-state decode plus FIFO push/pop/drop qualification.
    always_comb begin
        next_state_s = state_r;
        push_s       = 1'b0;
        drop_s       = 1'b0;
        final_s      = 1'b0;
        pop_s        = (count_r != {(PTR_W+1){1'b0}}) && m.ready;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = (WARMUP_WORDS == 0) ? ST_CAPTURE : ST_WARMUP;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WARMUP: begin
                if (stop) begin
                    next_state_s = ST_FLUSH;
                end else if (des_done_i && (warm_inc_s == WARMUP_L)) begin
                    next_state_s = ST_CAPTURE;
                end else begin
                    next_state_s = ST_WARMUP;
                end
            end
            ST_CAPTURE: begin
                if (des_done_i) begin
                    final_s = (num_words_r != {CNT_W{1'b0}}) && (cap_inc_s == num_words_r);
                    // A pop in the same cycle frees the slot being written.
                    if ((count_r < DEPTH_L) || pop_s) begin
                        push_s = 1'b1;
                    end else begin
                        drop_s = 1'b1;
                    end
                end else begin
                    final_s = 1'b0;
                end
                if (stop || final_s) begin
                    next_state_s = ST_FLUSH;
                end else begin
                    next_state_s = ST_CAPTURE;
                end
            end
            ST_FLUSH: begin
                if (count_r == {(PTR_W+1){1'b0}}) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_FLUSH;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Session state, latched controls, counters and registered status outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r        <= ST_IDLE;
            num_words_r    <= {CNT_W{1'b0}};
            irsel_r        <= 1'b0;
            des_enable_r   <= 1'b0;
            busy_r         <= 1'b0;
            capture_done_r <= 1'b0;
            overflow_r     <= 1'b0;
            drop_cnt_r     <= 8'd0;
            warm_cnt_r     <= {CNT_W{1'b0}};
            cap_cnt_r      <= {CNT_W{1'b0}};
        end else begin
            state_r        <= next_state_s;
            des_enable_r   <= (next_state_s == ST_WARMUP) || (next_state_s == ST_CAPTURE);
            busy_r         <= (next_state_s != ST_IDLE);
            capture_done_r <= (state_r == ST_FLUSH) && (next_state_s == ST_IDLE);
            if ((state_r == ST_IDLE) && start) begin
                num_words_r <= num_words;
                irsel_r     <= channel_sel;
                overflow_r  <= 1'b0;
                drop_cnt_r  <= 8'd0;
                warm_cnt_r  <= {CNT_W{1'b0}};
                cap_cnt_r   <= {CNT_W{1'b0}};
            end else begin
                if ((state_r == ST_WARMUP) && des_done_i) begin
                    warm_cnt_r <= warm_inc_s;
                end
                // Dropped words still count toward num_words.
                if ((state_r == ST_CAPTURE) && des_done_i) begin
                    cap_cnt_r <= cap_inc_s;
                end
                if (drop_s) begin
                    overflow_r <= 1'b1;
                    if (drop_cnt_r != 8'hFF) begin
                        drop_cnt_r <= drop_cnt_r + 8'd1;
                    end
                end
            end
        end
    end

    // FIFO pointers and occupancy; count disambiguates full from empty.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage; contents need no reset because count gates visibility.
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_data_r[wr_ptr_r] <= des_data_i;
            mem_last_r[wr_ptr_r] <= final_s;
        end
    end

    assign m.valid        = (count_r != {(PTR_W+1){1'b0}});
    assign m.data         = m.valid ? mem_data_r[rd_ptr_r] : {WORD_W{1'b0}};
    assign m.last         = m.valid ? mem_last_r[rd_ptr_r] : 1'b0;
    assign des_enable_o   = des_enable_r;
    assign des_irsel_o    = irsel_r;
    assign busy_o         = busy_r;
    assign capture_done_o = capture_done_r;
    assign overflow_o     = overflow_r;
    assign drop_cnt_o     = drop_cnt_r;
endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// tb_pdm_capture_ctrl
//   Directed bench for pdm_capture_ctrl with default parameters
//   (WORD_W=16, FIFO_DEPTH=8, WARMUP_WORDS=4, CNT_W=20).
module tb_pdm_capture_ctrl;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [19:0] num_words = 20'd0;
    logic        channel_sel = 1'b0;
    logic        des_enable_o, des_irsel_o;
    logic        des_done_i = 1'b0;
    logic [15:0] des_data_i = 16'd0;
    logic        busy_o, capture_done_o, overflow_o;
    logic [7:0]  drop_cnt_o;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int cd_cnt = 0;
    int cd0;
    logic [16:0] q [$];

    pdm_capture_ctrl_if #(.WORD_W(16)) m_if ();

    pdm_capture_ctrl dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start),
        .stop           (stop),
        .num_words      (num_words),
        .channel_sel    (channel_sel),
        .des_enable_o   (des_enable_o),
        .des_irsel_o    (des_irsel_o),
        .des_done_i     (des_done_i),
        .des_data_i     (des_data_i),
        .m              (m_if.master),
        .busy_o         (busy_o),
        .capture_done_o (capture_done_o),
        .overflow_o     (overflow_o),
        .drop_cnt_o     (drop_cnt_o)
    );

    always #5 clock = ~clock;

    // Record accepted stream words and done pulses mid-cycle.
    always @(negedge clock) begin
        if (m_if.valid && m_if.ready) q.push_back({m_if.last, m_if.data});
        if (capture_done_o) cd_cnt++;
    end

    // Hang guard.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] w);
        des_data_i = w;
        des_done_i = 1'b1;
        tick;
        des_done_i = 1'b0;
        des_data_i = 16'd0;
    endtask

    task automatic do_start(input logic [19:0] nw, input logic ch);
        num_words   = nw;
        channel_sel = ch;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic warmup;
        for (int i = 0; i < 4; i++) send(16'hEE00 + 16'(i));
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy_o && n < 200) begin
            tick;
            n++;
        end
        chk(tag, 32'(busy_o), 32'd0);
        tick;
    endtask

    initial begin
        m_if.ready = 1'b0;
        tick;
        tick;
        // Reset state
        chk("rst_valid", 32'(m_if.valid), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_en", 32'(des_enable_o), 32'd0);
        chk("rst_irsel", 32'(des_irsel_o), 32'd0);
        chk("rst_ovf", 32'(overflow_o), 32'd0);
        chk("rst_drop", 32'(drop_cnt_o), 32'd0);
        chk("rst_done", 32'(capture_done_o), 32'd0);
        reset_n = 1'b1;
        tick;

        // 1: warm-up discard, num_words=3
        m_if.ready = 1'b1;
        cd0 = cd_cnt;
        do_start(20'd3, 1'b0);
        chk("t1_busy", 32'(busy_o), 32'd1);
        chk("t1_en", 32'(des_enable_o), 32'd1);
        for (int i = 1; i <= 4; i++) send(16'(i));
        chk("t1_warm_novalid", 32'(m_if.valid), 32'd0);
        for (int i = 5; i <= 7; i++) send(16'(i));
        chk("t1_en_off", 32'(des_enable_o), 32'd0);
        wait_idle("t1_idle");
        chk("t1_qsize", q.size(), 32'd3);
        chk("t1_w0", 32'(q[0]), 32'h0_0005);
        chk("t1_w1", 32'(q[1]), 32'h0_0006);
        chk("t1_w2", 32'(q[2]), 32'h1_0007);
        chk("t1_done_cnt", cd_cnt - cd0, 32'd1);
        chk("t1_done_low", 32'(capture_done_o), 32'd0);

        // 2: backpressure overflow, num_words=12
        q.delete();
        m_if.ready = 1'b0;
        cd0 = cd_cnt;
        do_start(20'd12, 1'b0);
        warmup;
        for (int i = 1; i <= 12; i++) send(16'(100 + i));
        chk("t2_ovf", 32'(overflow_o), 32'd1);
        chk("t2_drop", 32'(drop_cnt_o), 32'd4);
        chk("t2_valid", 32'(m_if.valid), 32'd1);
        chk("t2_head", 32'(m_if.data), 32'd101);
        chk("t2_last", 32'(m_if.last), 32'd0);
        chk("t2_busy_flush", 32'(busy_o), 32'd1);
        chk("t2_en_off", 32'(des_enable_o), 32'd0);
        tick;
        chk("t2_hold", 32'(m_if.data), 32'd101);
        m_if.ready = 1'b1;
        wait_idle("t2_idle");
        chk("t2_qsize", q.size(), 32'd8);
        chk("t2_first", 32'(q[0]), 32'd101);
        chk("t2_lastw", 32'(q[7]), 32'd108);
        chk("t2_done_cnt", cd_cnt - cd0, 32'd1);
        chk("t2_ovf_hold", 32'(overflow_o), 32'd1);
        chk("t2_drop_hold", 32'(drop_cnt_o), 32'd4);

        // 3: continuous with stop on 5th word; ignored start mid-session
        q.delete();
        cd0 = cd_cnt;
        do_start(20'd0, 1'b1);
        chk("t3_irsel", 32'(des_irsel_o), 32'd1);
        chk("t3_ovf_clr", 32'(overflow_o), 32'd0);
        chk("t3_drop_clr", 32'(drop_cnt_o), 32'd0);
        warmup;
        for (int i = 1; i <= 4; i++) send(16'(200 + i));
        do_start(20'd5, 1'b0);
        chk("t3_irsel_keep", 32'(des_irsel_o), 32'd1);
        chk("t3_busy_keep", 32'(busy_o), 32'd1);
        stop = 1'b1;
        send(16'd205);
        stop = 1'b0;
        chk("t3_en_off", 32'(des_enable_o), 32'd0);
        wait_idle("t3_idle");
        chk("t3_qsize", q.size(), 32'd5);
        chk("t3_first", 32'(q[0]), 32'd201);
        chk("t3_fifth", 32'(q[4]), 32'd205);
        chk("t3_done_cnt", cd_cnt - cd0, 32'd1);

        // 6: stop while idle is ignored
        stop = 1'b1;
        tick;
        stop = 1'b0;
        chk("t6_stop_busy", 32'(busy_o), 32'd0);
        chk("t6_stop_en", 32'(des_enable_o), 32'd0);

        // 4: full FIFO with simultaneous push and pop; start+stop in idle
        q.delete();
        m_if.ready = 1'b0;
        stop = 1'b1;
        do_start(20'd0, 1'b0);
        stop = 1'b0;
        chk("t4_startwins", 32'(busy_o), 32'd1);
        chk("t4_en", 32'(des_enable_o), 32'd1);
        warmup;
        for (int i = 1; i <= 8; i++) send(16'(300 + i));
        chk("t4_full_drop", 32'(drop_cnt_o), 32'd0);
        m_if.ready = 1'b1;
        send(16'd309);
        m_if.ready = 1'b0;
        chk("t4_pp_drop", 32'(drop_cnt_o), 32'd0);
        chk("t4_pp_ovf", 32'(overflow_o), 32'd0);
        send(16'd310);
        chk("t4_still_full", 32'(drop_cnt_o), 32'd1);
        stop = 1'b1;
        tick;
        stop = 1'b0;
        m_if.ready = 1'b1;
        wait_idle("t4_idle");
        chk("t4_qsize", q.size(), 32'd9);
        chk("t4_q0", 32'(q[0]), 32'd301);
        chk("t4_q1", 32'(q[1]), 32'd302);
        chk("t4_q8", 32'(q[8]), 32'd309);

        // 5: reset mid-capture with 3 words buffered
        q.delete();
        m_if.ready = 1'b0;
        cd0 = cd_cnt;
        do_start(20'd0, 1'b1);
        warmup;
        for (int i = 1; i <= 3; i++) send(16'(400 + i));
        chk("t5_valid", 32'(m_if.valid), 32'd1);
        chk("t5_head", 32'(m_if.data), 32'd401);
        reset_n = 1'b0;
        tick;
        reset_n = 1'b1;
        chk("t5_valid_clr", 32'(m_if.valid), 32'd0);
        chk("t5_busy_clr", 32'(busy_o), 32'd0);
        chk("t5_en_clr", 32'(des_enable_o), 32'd0);
        chk("t5_irsel_clr", 32'(des_irsel_o), 32'd0);
        chk("t5_data_clr", 32'(m_if.data), 32'd0);
        m_if.ready = 1'b1;
        do_start(20'd2, 1'b0);
        warmup;
        send(16'd501);
        send(16'd502);
        wait_idle("t5_idle");
        chk("t5_qsize", q.size(), 32'd2);
        chk("t5_q0", 32'(q[0]), 32'h0_01F5);
        chk("t5_q1", 32'(q[1]), 32'h1_01F6);
        chk("t5_done_cnt", cd_cnt - cd0, 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
